// File: rtl/semaforo_pkg.sv
// Shared light encodings, violation codes, default dwell times and
// the per-sample classification used by the traffic-light monitor.
package semaforo_pkg;

  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;

  localparam logic [7:0] DEF_VERDE    = 8'd1;
  localparam logic [7:0] DEF_AMARELO  = 8'd3;
  localparam logic [7:0] DEF_VERMELHO = 8'd2;
  localparam logic [7:0] CONT_MAX     = 8'hFF;

  typedef enum logic [2:0] {
    ERR_NENHUM   = 3'd0,
    ERR_CODIF    = 3'd1,
    ERR_CONFLITO = 3'd2,
    ERR_SEQ      = 3'd3,
    ERR_DUR      = 3'd4
  } cod_erro_e;

  // How one light's current sample relates to its recorded history.
  typedef enum logic [2:0] {
    MUD_INVALIDO = 3'd0,  // sample not one-hot
    MUD_CARGA    = 3'd1,  // first legal sample, history just loaded
    MUD_MANTEM   = 3'd2,  // same state as previous sample
    MUD_AVANCA   = 3'd3,  // legal successor of previous state
    MUD_SALTO    = 3'd4   // any other change
  } mudanca_e;

  function automatic logic eh_onehot(input logic [2:0] luz);
    return (luz == LUZ_VERDE) || (luz == LUZ_AMARELO) || (luz == LUZ_VERMELHO);
  endfunction

  function automatic logic [2:0] proxima_luz(input logic [2:0] luz);
    case (luz)
      LUZ_VERDE:    return LUZ_AMARELO;
      LUZ_AMARELO:  return LUZ_VERMELHO;
      LUZ_VERMELHO: return LUZ_VERDE;
      default:      return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/semaforo_monitor_lamp_checker.sv
// Per-light history tracker: one-hot check, valid bit, previous state, sequence class.
// Classification is combinational on the current sample; history updates on the clock edge.
module lamp_checker
  import semaforo_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] luz_i,
  output mudanca_e   mud_o
);

  logic       valido_q, valido_d;
  logic [2:0] prev_q, prev_d;

  always_comb begin
    valido_d = 1'b0;
    prev_d   = prev_q;
    mud_o    = MUD_INVALIDO;
    if (eh_onehot(luz_i)) begin
      valido_d = 1'b1;
      prev_d   = luz_i;
      if (!valido_q)
        mud_o = MUD_CARGA;
      else if (luz_i == prev_q)
        mud_o = MUD_MANTEM;
      else if (luz_i == proxima_luz(prev_q))
        mud_o = MUD_AVANCA;
      else
        mud_o = MUD_SALTO;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valido_q <= 1'b0;
      prev_q   <= 3'b000;
    end else begin
      valido_q <= valido_d;
      prev_q   <= prev_d;
    end
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Two-light traffic signal monitor: encoding, conflict, sequence and A-dwell checks.
// Outputs registered, updated on the same edge that samples A/B; no flow control.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter logic [7:0] VERDE    = DEF_VERDE,
  parameter logic [7:0] AMARELO  = DEF_AMARELO,
  parameter logic [7:0] VERMELHO = DEF_VERMELHO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       erro,
  output logic [2:0] cod_erro,
  output logic [7:0] ciclos
);

  mudanca_e   mud_a, mud_b;
  logic       viol_codif, viol_conflito, viol_seq, viol_dur;
  logic       troca_a;
  logic [7:0] esperado;
  logic [7:0] dwell_q, dwell_d;
  logic       dwell_chk_q, dwell_chk_d;
  logic [7:0] ciclos_q, ciclos_d;
  logic       erro_q, erro_d;
  cod_erro_e  cod_q, cod_d, cod_viol;

  lamp_checker u_lamp_a (.clk_i(clk), .rst_i(rst), .luz_i(A), .mud_o(mud_a));
  lamp_checker u_lamp_b (.clk_i(clk), .rst_i(rst), .luz_i(B), .mud_o(mud_b));

  assign troca_a = (mud_a == MUD_AVANCA) || (mud_a == MUD_SALTO);

  // Dwell required for the state A is leaving. On a legal advance that state is
  // the predecessor of A; on an illegal jump code 3 outranks code 4 anyway.
  always_comb begin
    esperado = VERMELHO;
    case (A)
      LUZ_AMARELO:  esperado = VERDE;
      LUZ_VERMELHO: esperado = AMARELO;
      default:      esperado = VERMELHO;
    endcase
  end

  always_comb begin
    viol_codif    = (mud_a == MUD_INVALIDO) || (mud_b == MUD_INVALIDO);
    viol_conflito = !viol_codif && (A != LUZ_VERMELHO) && (B != LUZ_VERMELHO);
    viol_seq      = (mud_a == MUD_SALTO) || (mud_b == MUD_SALTO);
    viol_dur      = troca_a && dwell_chk_q && (dwell_q != esperado);

    if (viol_codif)         cod_viol = ERR_CODIF;
    else if (viol_conflito) cod_viol = ERR_CONFLITO;
    else if (viol_seq)      cod_viol = ERR_SEQ;
    else if (viol_dur)      cod_viol = ERR_DUR;
    else                    cod_viol = ERR_NENHUM;
  end

  // The first dwell after a history load is partial, so only dwells that
  // began on a checked transition are timed.
  always_comb begin
    dwell_d     = dwell_q;
    dwell_chk_d = dwell_chk_q;
    ciclos_d    = ciclos_q;
    erro_d      = erro_q;
    cod_d       = cod_q;
    case (mud_a)
      MUD_CARGA: begin
        dwell_d     = 8'd1;
        dwell_chk_d = 1'b0;
      end
      MUD_MANTEM: begin
        if (dwell_q != CONT_MAX) dwell_d = dwell_q + 8'd1;
      end
      MUD_AVANCA, MUD_SALTO: begin
        dwell_d     = 8'd1;
        dwell_chk_d = 1'b1;
      end
      default: ;
    endcase
    if ((mud_a == MUD_AVANCA) && (A == LUZ_VERDE) && (ciclos_q != CONT_MAX))
      ciclos_d = ciclos_q + 8'd1;
    if (!erro_q && (cod_viol != ERR_NENHUM)) begin
      erro_d = 1'b1;
      cod_d  = cod_viol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q     <= 8'd0;
      dwell_chk_q <= 1'b0;
      ciclos_q    <= 8'd0;
      erro_q      <= 1'b0;
      cod_q       <= ERR_NENHUM;
    end else begin
      dwell_q     <= dwell_d;
      dwell_chk_q <= dwell_chk_d;
      ciclos_q    <= ciclos_d;
      erro_q      <= erro_d;
      cod_q       <= cod_d;
    end
  end

  assign erro     = erro_q;
  assign cod_erro = cod_q;
  assign ciclos   = ciclos_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor with default dwell parameters.
module tb_semaforo_monitor;

  localparam logic [2:0] V = 3'b001;
  localparam logic [2:0] M = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk;
  logic       rst;
  logic [2:0] A, B;
  logic       erro;
  logic [2:0] cod_erro;
  logic [7:0] ciclos;

  int n_tests;
  int n_fail;

  semaforo_monitor dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .erro    (erro),
    .cod_erro(cod_erro),
    .ciclos  (ciclos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic passo(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    A   = 3'b011;
    B   = 3'b111;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_erro"}, erro, 0);
    check({tag, "_cod"}, cod_erro, 0);
    check({tag, "_ciclos"}, ciclos, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    A   = 3'b000;
    B   = 3'b000;

    // Reset state, with garbage on A/B during reset
    reset_dut();
    check_zero("reset");

    // Legal stream: three full A cycles; B red except during A red
    for (int r = 0; r < 3; r++) begin
      passo(V, R); check("legal_erro", erro, 0);
      for (int k = 0; k < 3; k++) begin
        passo(M, R); check("legal_erro", erro, 0);
      end
      passo(R, V); check("legal_erro", erro, 0);
      passo(R, M); check("legal_erro", erro, 0);
      check("legal_ciclos", ciclos, r);
    end

    // Illegal encoding mid-stream, then legal samples keep code 1
    passo(3'b011, R);
    check("codif_erro", erro, 1);
    check("codif_cod", cod_erro, 1);
    passo(V, R);
    passo(M, R);
    check("codif_sticky", cod_erro, 1);
    check("codif_reload_ciclos", ciclos, 2);

    // Both green -> conflict
    reset_dut();
    passo(V, V);
    check("conflito_erro", erro, 1);
    check("conflito_cod", cod_erro, 2);

    // Verde -> vermelho after a checked verde dwell
    reset_dut();
    passo(R, R);
    passo(V, R);
    check("seq_ciclos", ciclos, 1);
    check("seq_pre_erro", erro, 0);
    passo(R, R);
    check("seq_cod", cod_erro, 3);

    // Amarelo held 4 cycles -> bad duration
    reset_dut();
    passo(R, R);
    passo(V, R);
    for (int k = 0; k < 4; k++) passo(M, R);
    check("dur_pre_erro", erro, 0);
    passo(R, R);
    check("dur_cod", cod_erro, 4);

    // Vermelho->verde with wrong dwell still counts a cycle
    reset_dut();
    passo(R, R);
    passo(V, R);
    for (int k = 0; k < 3; k++) passo(M, R);
    for (int k = 0; k < 3; k++) passo(R, R);
    check("durciclo_pre_erro", erro, 0);
    passo(V, R);
    check("durciclo_cod", cod_erro, 4);
    check("durciclo_ciclos", ciclos, 2);

    // A=000 together with a B sequence error -> lowest code (1)
    reset_dut();
    passo(V, R);
    passo(3'b000, M);
    check("prio_codif", cod_erro, 1);

    // Conflict together with an A sequence error -> code 2
    reset_dut();
    passo(M, R);
    passo(M, R);
    passo(V, V);
    check("prio_conflito", cod_erro, 2);

    // Mid-stream reset clears everything; partial first dwell is exempt
    reset_dut();
    passo(R, R);
    passo(V, R);
    passo(V, V);
    check("midrst_pre_erro", erro, 1);
    check("midrst_pre_ciclos", ciclos, 1);
    reset_dut();
    check_zero("midrst");
    for (int k = 0; k < 5; k++) passo(M, R);
    passo(R, V);
    check("midrst_partial_erro", erro, 0);
    passo(R, M);
    passo(V, R);
    check("midrst_post_erro", erro, 0);
    check("midrst_post_ciclos", ciclos, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
